execute_operand_stage: RTL and testbench



---
 rtl/execute_operand_stage.sv | 80 ++++++++
 tb/tb_execute_operand_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_operand_stage.sv
// execute_operand_stage: bypass-resolved operand capture into an in-order valid/ready buffer
module execute_operand_stage #(
  parameter int DATA_W  = 16,
  parameter int ECTRL_W = 6,
  parameter int NUM_BYP = 2,
  parameter int DEPTH   = 2,
  parameter int SEL_W   = $clog2(NUM_BYP+1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_execute,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ECTRL_W-1:0]        E_control,
  input  logic [DATA_W-1:0]         IR,
  input  logic [DATA_W-1:0]         npc_in,
  input  logic [DATA_W-1:0]         VSR1,
  input  logic [DATA_W-1:0]         VSR2,
  input  logic [SEL_W-1:0]          byp_sel_1,
  input  logic [SEL_W-1:0]          byp_sel_2,
  input  logic [NUM_BYP*DATA_W-1:0] byp_data,
  input  logic [1:0]                W_Control_in,
  input  logic                      Mem_Control_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         aluin1,
  output logic [DATA_W-1:0]         aluin2,
  output logic [DATA_W-1:0]         IR_out,
  output logic [DATA_W-1:0]         npc_out,
  output logic [ECTRL_W-1:0]        E_control_out,
  output logic [1:0]                W_Control_out,
  output logic                      Mem_Control_out,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4*DATA_W + ECTRL_W + 3;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata, head, last;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] op1, op2;
  logic push, pop;
  always_comb begin
    op1 = VSR1;
    op2 = VSR2;
    for (int k = 0; k < NUM_BYP; k++) begin
      op1 = (byp_sel_1 == SEL_W'(k+1)) ? byp_data[k*DATA_W +: DATA_W] : op1;
      op2 = (byp_sel_2 == SEL_W'(k+1)) ? byp_data[k*DATA_W +: DATA_W] : op2;
    end
  end
  assign wdata     = {op1, op2, IR, npc_in, E_control, W_Control_in, Mem_Control_in};
  assign in_ready  = ~reset & enable_execute & ~flush & (count < (AW+1)'(DEPTH));
  assign out_valid = enable_execute & (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // an empty buffer keeps presenting the last head so outputs never glitch
  assign head      = (count != '0) ? mem[rd_ptr] : last;
  assign {aluin1, aluin2, IR_out, npc_out, E_control_out, W_Control_out, Mem_Control_out} = head;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
    end else begin
      last <= head;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
        count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= wdata;
endmodule

// File: tb/tb_execute_operand_stage.sv
// tb_execute_operand_stage: queue-model scoreboard plus directed literal checks
module tb_execute_operand_stage;
  localparam int DW = 16, CW = 6, NB = 2, D = 2, SW = 2;
  logic clock = 0, reset = 1, en = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] ectl = '0;
  logic [DW-1:0] ir = '0, npc = '0, vsr1 = '0, vsr2 = '0;
  logic [SW-1:0] s1 = '0, s2 = '0;
  logic [NB*DW-1:0] byp = '0;
  logic [1:0] wc = '0;
  logic mc = 0;
  logic in_ready, out_valid, mc_o;
  logic [DW-1:0] a1, a2, ir_o, npc_o;
  logic [CW-1:0] ectl_o;
  logic [1:0] wc_o;
  logic [$clog2(D):0] count;

  execute_operand_stage #(.DATA_W(DW), .ECTRL_W(CW), .NUM_BYP(NB), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .enable_execute(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .E_control(ectl), .IR(ir), .npc_in(npc),
    .VSR1(vsr1), .VSR2(vsr2), .byp_sel_1(s1), .byp_sel_2(s2), .byp_data(byp),
    .W_Control_in(wc), .Mem_Control_in(mc), .out_valid(out_valid), .out_ready(out_ready),
    .aluin1(a1), .aluin2(a2), .IR_out(ir_o), .npc_out(npc_o), .E_control_out(ectl_o),
    .W_Control_out(wc_o), .Mem_Control_out(mc_o), .count(count));

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] a1, a2, ir, npc;
    logic [CW-1:0] e;
    logic [1:0] w;
    logic m;
  } ent_t;

  ent_t q[$];
  ent_t hold;
  bit armed = 0;
  int total = 0, bad = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pick(logic [SW-1:0] s, logic [DW-1:0] v);
    int idx;
    if (s == 0 || int'(s) > NB) return v;
    idx = int'(s) - 1;
    return byp[idx*DW +: DW];
  endfunction

  function automatic ent_t cur();
    ent_t e;
    e.a1 = pick(s1, vsr1);
    e.a2 = pick(s2, vsr2);
    e.ir = ir;
    e.npc = npc;
    e.e = ectl;
    e.w = wc;
    e.m = mc;
    return e;
  endfunction

  always @(posedge clock) begin
    int n;
    bit pu, po;
    if (reset) begin
      q.delete();
      hold = '{default: 0};
      armed = 1;
    end else begin
      n = q.size();
      if (n != 0) hold = q[0];
      if (flush) q.delete();
      else if (en) begin
        po = (n != 0) && out_ready;
        pu = in_valid && (n < D);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(cur());
      end
    end
  end

  always @(negedge clock) begin
    ent_t e;
    if (armed) begin
      e = (q.size() != 0) ? q[0] : hold;
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(!reset && en && !flush && q.size() < D));
      chk("out_valid", 32'(out_valid), 32'(en && q.size() != 0));
      chk("aluin1", 32'(a1), 32'(e.a1));
      chk("aluin2", 32'(a2), 32'(e.a2));
      chk("IR_out", 32'(ir_o), 32'(e.ir));
      chk("npc_out", 32'(npc_o), 32'(e.npc));
      chk("E_control_out", 32'(ectl_o), 32'(e.e));
      chk("W_Control_out", 32'(wc_o), 32'(e.w));
      chk("Mem_Control_out", 32'(mc_o), 32'(e.m));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tick();
    tick();
    @(negedge clock);
    chk("lit_rst_in_ready", 32'(in_ready), 0);
    reset = 0;
    en = 1;
    @(negedge clock);
    chk("lit_rst_count", 32'(count), 0);
    chk("lit_rst_out_valid", 32'(out_valid), 0);
    chk("lit_rst_aluin1", 32'(a1), 0);
    chk("lit_rst_IR_out", 32'(ir_o), 0);
    chk("lit_post_rst_in_ready", 32'(in_ready), 1);
    ir = 16'h1234; vsr1 = 16'h0005; vsr2 = 16'h0007; in_valid = 1;
    tick();
    in_valid = 0;
    @(negedge clock);
    chk("lit_basic_valid", 32'(out_valid), 1);
    chk("lit_basic_a1", 32'(a1), 32'h0005);
    chk("lit_basic_a2", 32'(a2), 32'h0007);
    chk("lit_basic_ir", 32'(ir_o), 32'h1234);
    chk("lit_basic_count", 32'(count), 1);
    en = 0;
    repeat (3) begin
      tick();
      @(negedge clock);
      chk("lit_stall_valid", 32'(out_valid), 0);
      chk("lit_stall_ready", 32'(in_ready), 0);
      chk("lit_stall_count", 32'(count), 1);
      chk("lit_stall_ir", 32'(ir_o), 32'h1234);
    end
    en = 1;
    @(negedge clock);
    chk("lit_resume_valid", 32'(out_valid), 1);
    chk("lit_resume_ir", 32'(ir_o), 32'h1234);
    out_ready = 1;
    tick();
    out_ready = 0;
    @(negedge clock);
    chk("lit_pop_count", 32'(count), 0);
    chk("lit_pop_hold_ir", 32'(ir_o), 32'h1234);
    byp = {16'hBBBB, 16'hAAAA}; s1 = 1; s2 = 2; ir = 16'h0002; in_valid = 1;
    tick();
    in_valid = 0;
    byp = '0;
    @(negedge clock);
    chk("lit_byp_a1", 32'(a1), 32'hAAAA);
    chk("lit_byp_a2", 32'(a2), 32'hBBBB);
    @(negedge clock);
    chk("lit_byp_sampled_a1", 32'(a1), 32'hAAAA);
    ir = 16'h0003; vsr1 = 16'h1111; vsr2 = 16'h2222; s1 = 3; s2 = 0;
    in_valid = 1; out_ready = 1;
    tick();
    in_valid = 0; out_ready = 0;
    @(negedge clock);
    chk("lit_sel3_a1", 32'(a1), 32'h1111);
    chk("lit_sel0_a2", 32'(a2), 32'h2222);
    chk("lit_pushpop_ir", 32'(ir_o), 32'h0003);
    chk("lit_pushpop_count", 32'(count), 1);
    flush = 1; in_valid = 1; ir = 16'h0009;
    tick();
    flush = 0; in_valid = 0;
    @(negedge clock);
    chk("lit_flush1_count", 32'(count), 0);
    chk("lit_flush1_valid", 32'(out_valid), 0);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      ir = 16'h0010 + 16'(i);
      tick();
    end
    in_valid = 0;
    @(negedge clock);
    chk("lit_full_count", 32'(count), 2);
    chk("lit_full_ready", 32'(in_ready), 0);
    chk("lit_full_head", 32'(ir_o), 32'h0010);
    out_ready = 1;
    #1;
    chk("lit_full_pop_ready", 32'(in_ready), 0);
    tick();
    @(negedge clock);
    chk("lit_drain_ir", 32'(ir_o), 32'h0011);
    chk("lit_drain_ready", 32'(in_ready), 1);
    tick();
    @(negedge clock);
    chk("lit_drain_count", 32'(count), 0);
    out_ready = 0; in_valid = 1; ir = 16'h0020;
    tick();
    ir = 16'h0021;
    tick();
    @(negedge clock);
    chk("lit_prefl_count", 32'(count), 2);
    flush = 1;
    tick();
    flush = 0; in_valid = 0;
    @(negedge clock);
    chk("lit_flush2_count", 32'(count), 0);
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      ir = 16'(i);
      tick();
      @(negedge clock);
      chk("lit_stream_ir", 32'(ir_o), 32'(i));
      chk("lit_stream_count", 32'(count), 1);
    end
    vsr1 = 16'h5555; s1 = 0;
    tick();
    reset = 1;
    tick();
    @(negedge clock);
    chk("lit_midrst_count", 32'(count), 0);
    chk("lit_midrst_valid", 32'(out_valid), 0);
    chk("lit_midrst_ir", 32'(ir_o), 0);
    chk("lit_midrst_a1", 32'(a1), 0);
    reset = 0;
    repeat (3000) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      en = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      ir = DW'($urandom); npc = DW'($urandom);
      vsr1 = DW'($urandom); vsr2 = DW'($urandom);
      byp = (NB*DW)'({$urandom, $urandom});
      s1 = SW'($urandom); s2 = SW'($urandom);
      ectl = CW'($urandom); wc = 2'($urandom); mc = 1'($urandom);
    end
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
